// File: rtl/kernel_weight_store_if.sv
// kernel_weight_store_if
// Bundles the loader, swap and read-port signals of the kernel weight store.
// The master side is the loader/conv engine; the slave side is the store itself.
interface kernel_weight_store_if #(
   parameter int DATA_WIDTH = 36,
   parameter int ADDR_WIDTH = 6
);

   logic                  load_start;
   logic                  load_valid;
   logic [DATA_WIDTH-1:0] load_data;
   logic                  load_ready;
   logic                  load_done;
   logic                  shadow_full;
   logic                  swap_req;
   logic                  swap_ack;
   logic                  active_bank;
   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;

   modport master (
      output load_start, load_valid, load_data, swap_req, rd_en, rd_addr,
      input  load_ready, load_done, shadow_full, swap_ack, active_bank, rd_data, rd_valid
   );

   modport slave (
      input  load_start, load_valid, load_data, swap_req, rd_en, rd_addr,
      output load_ready, load_done, shadow_full, swap_ack, active_bank, rd_data, rd_valid
   );

endinterface

// File: rtl/kernel_weight_store.sv
// kernel_weight_store
// Ping-pong kernel weight memory: the conv engine reads the active bank while a
// streaming loader fills the shadow bank; a swap handshake flips the banks once
// the shadow set is complete and no read is in flight that cycle.
module kernel_weight_store #(
   parameter int KERNEL_WEIGHT_BITS = 6,
   parameter int KERNEL_SIZE        = 3,
   parameter int IN_CHANNELS        = 6,
   parameter int OUT_CHANNELS       = 6,
   parameter int DATA_WIDTH         = KERNEL_WEIGHT_BITS * OUT_CHANNELS,
   parameter int DEPTH              = IN_CHANNELS * KERNEL_SIZE * KERNEL_SIZE,
   parameter int ADDR_WIDTH         = $clog2(DEPTH)
) (
   input logic                  clk,
   input logic                  rst,
   kernel_weight_store_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      LOADING,
      FULL
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic                  r_load_ready;
   logic                  r_load_done;
   logic                  r_shadow_full;
   logic                  r_swap_ack;
   logic                  r_active_bank;
   logic [DATA_WIDTH-1:0] r_rd_data;
   logic                  r_rd_valid;

   logic [DATA_WIDTH-1:0] r_bank0 [DEPTH];
   logic [DATA_WIDTH-1:0] r_bank1 [DEPTH];

   logic                  w_wr_en;
   logic [ADDR_WIDTH-1:0] w_wr_addr;
   logic                  w_rd_in_range;

   // A restart that arrives together with a word writes that word at address 0.
   assign w_wr_en       = (r_state == LOADING) && bus.load_valid;
   assign w_wr_addr     = bus.load_start ? '0 : r_wr_ptr;
   assign w_rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_EXT);

   // Load/swap FSM with all handshake outputs registered alongside the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_wr_ptr      <= '0;
         r_load_ready  <= 1'b0;
         r_load_done   <= 1'b0;
         r_shadow_full <= 1'b0;
         r_swap_ack    <= 1'b0;
         r_active_bank <= 1'b0;
      end else begin
         r_load_done <= 1'b0;
         r_swap_ack  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.load_start) begin
                  r_wr_ptr     <= '0;
                  r_load_ready <= 1'b1;
                  r_state      <= LOADING;
               end
            end
            LOADING: begin
               if (bus.load_start) begin
                  r_wr_ptr <= bus.load_valid ? ADDR_WIDTH'(1) : '0;
               end else if (bus.load_valid) begin
                  if (r_wr_ptr == LAST_ADDR) begin
                     r_wr_ptr      <= '0;
                     r_load_ready  <= 1'b0;
                     r_shadow_full <= 1'b1;
                     r_load_done   <= 1'b1;
                     r_state       <= FULL;
                  end else begin
                     r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
                  end
               end
            end
            FULL: begin
               if (bus.load_start) begin
                  r_wr_ptr      <= '0;
                  r_load_ready  <= 1'b1;
                  r_shadow_full <= 1'b0;
                  r_state       <= LOADING;
               end else if (bus.swap_req && !bus.rd_en) begin
                  r_active_bank <= ~r_active_bank;
                  r_swap_ack    <= 1'b1;
                  r_shadow_full <= 1'b0;
                  r_state       <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Shadow-bank write port; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         if (r_active_bank) begin
            r_bank0[w_wr_addr] <= bus.load_data;
         end else begin
            r_bank1[w_wr_addr] <= bus.load_data;
         end
      end
   end

   // Registered read of the active bank; out-of-range addresses read as zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= bus.rd_en;
         if (bus.rd_en) begin
            if (!w_rd_in_range) begin
               r_rd_data <= '0;
            end else if (r_active_bank) begin
               r_rd_data <= r_bank1[bus.rd_addr];
            end else begin
               r_rd_data <= r_bank0[bus.rd_addr];
            end
         end
      end
   end

   assign bus.load_ready  = r_load_ready;
   assign bus.load_done   = r_load_done;
   assign bus.shadow_full = r_shadow_full;
   assign bus.swap_ack    = r_swap_ack;
   assign bus.active_bank = r_active_bank;
   assign bus.rd_data     = r_rd_data;
   assign bus.rd_valid    = r_rd_valid;

endmodule

// File: tb/tb_kernel_weight_store.sv
// tb_kernel_weight_store
// Directed sequence with random weight patterns, checked against a two-bank
// array model of the store kept in the bench.
module tb_kernel_weight_store;

   localparam int KWB   = 6;
   localparam int KS    = 3;
   localparam int IC    = 6;
   localparam int OC    = 6;
   localparam int DW    = KWB * OC;
   localparam int DEPTH = IC * KS * KS;
   localparam int AW    = $clog2(DEPTH);

   logic clk;
   logic rst;

   kernel_weight_store_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   kernel_weight_store #(
      .KERNEL_WEIGHT_BITS(KWB),
      .KERNEL_SIZE(KS),
      .IN_CHANNELS(IC),
      .OUT_CHANNELS(OC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   logic [DW-1:0] bankModel [2][DEPTH];
   int            modelActive;
   int            assertCount;
   int            failCount;
   int            doneCount;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      assertCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   function automatic logic [DW-1:0] expRead(input int addr);
      if (addr >= DEPTH) return '0;
      return bankModel[modelActive][addr];
   endfunction

   // Streams n words into the shadow bank, optionally reading the active bank alongside.
   task automatic applyStimulus(input int n, input bit concurrentStart, input bit readDuring, input bit randomData);
      int            shadow;
      int            addr;
      logic [DW-1:0] word;
      logic [DW-1:0] expRd;
      shadow = 1 - modelActive;
      expRd  = '0;
      if (!concurrentStart) begin
         bus.load_start = 1'b1;
         tick();
         bus.load_start = 1'b0;
      end
      for (int i = 0; i < n; i++) begin
         word = randomData ? DW'({$urandom(), $urandom()}) : DW'(i);
         bus.load_start = concurrentStart && (i == 0);
         bus.load_valid = 1'b1;
         bus.load_data  = word;
         checkOutput("load_ready", 64'(bus.load_ready), 64'd1);
         if (readDuring) begin
            addr        = $urandom_range(0, DEPTH - 1);
            bus.rd_en   = 1'b1;
            bus.rd_addr = AW'(addr);
            expRd       = expRead(addr);
         end
         tick();
         bankModel[shadow][i] = word;
         if (bus.load_done) doneCount++;
         checkOutput("load_done", 64'(bus.load_done), 64'(i == DEPTH - 1));
         if (readDuring) begin
            checkOutput("rd_valid_during_load", 64'(bus.rd_valid), 64'd1);
            checkOutput("rd_data_during_load", 64'(bus.rd_data), 64'(expRd));
         end
      end
      bus.load_start = 1'b0;
      bus.load_valid = 1'b0;
      bus.rd_en      = 1'b0;
   endtask

   task automatic readSweep(input string tag);
      for (int a = 0; a < DEPTH; a++) begin
         bus.rd_en   = 1'b1;
         bus.rd_addr = AW'(a);
         tick();
         checkOutput(tag, 64'(bus.rd_data), 64'(expRead(a)));
      end
      bus.rd_en = 1'b0;
   endtask

   task automatic doSwap();
      bus.swap_req = 1'b1;
      bus.rd_en    = 1'b0;
      tick();
      modelActive = 1 - modelActive;
      checkOutput("swap_ack", 64'(bus.swap_ack), 64'd1);
      checkOutput("active_bank_after_swap", 64'(bus.active_bank), 64'(modelActive));
      checkOutput("shadow_full_after_swap", 64'(bus.shadow_full), 64'd0);
      bus.swap_req = 1'b0;
      tick();
      checkOutput("swap_ack_single", 64'(bus.swap_ack), 64'd0);
   endtask

   // Linear directed sequence of load, swap, read and reset scenarios.
   initial begin
      int addr;
      int expBank;
      logic [DW-1:0] expRd;
      assertCount    = 0;
      failCount      = 0;
      doneCount      = 0;
      modelActive    = 0;
      rst            = 1'b1;
      bus.load_start = 1'b0;
      bus.load_valid = 1'b0;
      bus.load_data  = '0;
      bus.swap_req   = 1'b0;
      bus.rd_en      = 1'b0;
      bus.rd_addr    = '0;
      tick();
      tick();
      rst = 1'b0;
      tick();

      checkOutput("reset_load_ready", 64'(bus.load_ready), 64'd0);
      checkOutput("reset_load_done", 64'(bus.load_done), 64'd0);
      checkOutput("reset_shadow_full", 64'(bus.shadow_full), 64'd0);
      checkOutput("reset_swap_ack", 64'(bus.swap_ack), 64'd0);
      checkOutput("reset_active_bank", 64'(bus.active_bank), 64'd0);
      checkOutput("reset_rd_data", 64'(bus.rd_data), 64'd0);
      checkOutput("reset_rd_valid", 64'(bus.rd_valid), 64'd0);

      $display("[TB] swap request while idle");
      bus.swap_req = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         checkOutput("idle_swap_ack", 64'(bus.swap_ack), 64'd0);
         checkOutput("idle_active_bank", 64'(bus.active_bank), 64'd0);
      end
      bus.swap_req = 1'b0;

      $display("[TB] address-pattern load into bank 1");
      doneCount = 0;
      applyStimulus(DEPTH, 1'b0, 1'b0, 1'b0);
      checkOutput("shadow_full_at_done", 64'(bus.shadow_full), 64'd1);
      tick();
      checkOutput("load_done_pulse_end", 64'(bus.load_done), 64'd0);
      checkOutput("shadow_full_hold", 64'(bus.shadow_full), 64'd1);
      checkOutput("load_ready_full", 64'(bus.load_ready), 64'd0);
      checkOutput("done_count_first", 64'(doneCount), 64'd1);
      doSwap();

      $display("[TB] latency and range reads");
      bus.rd_en   = 1'b1;
      bus.rd_addr = AW'(17);
      tick();
      checkOutput("rd_valid_17", 64'(bus.rd_valid), 64'd1);
      checkOutput("rd_data_17", 64'(bus.rd_data), 64'd17);
      bus.rd_en = 1'b0;
      tick();
      checkOutput("rd_valid_drop", 64'(bus.rd_valid), 64'd0);
      checkOutput("rd_data_hold", 64'(bus.rd_data), 64'd17);
      bus.rd_en   = 1'b1;
      bus.rd_addr = AW'(DEPTH);
      tick();
      checkOutput("rd_valid_oob", 64'(bus.rd_valid), 64'd1);
      checkOutput("rd_data_oob", 64'(bus.rd_data), 64'd0);
      addr        = $urandom_range(DEPTH, (1 << AW) - 1);
      bus.rd_addr = AW'(addr);
      tick();
      checkOutput("rd_data_oob_rand", 64'(bus.rd_data), 64'd0);
      bus.rd_en = 1'b0;
      tick();

      $display("[TB] load bank 0 while reading bank 1");
      applyStimulus(DEPTH, 1'b0, 1'b1, 1'b1);
      tick();

      $display("[TB] swap deferred by reads");
      bus.swap_req = 1'b1;
      for (int k = 0; k < 5; k++) begin
         addr        = $urandom_range(0, DEPTH - 1);
         bus.rd_en   = 1'b1;
         bus.rd_addr = AW'(addr);
         expRd       = expRead(addr);
         tick();
         checkOutput("deferred_swap_ack", 64'(bus.swap_ack), 64'd0);
         checkOutput("deferred_active_bank", 64'(bus.active_bank), 64'(modelActive));
         checkOutput("deferred_rd_data", 64'(bus.rd_data), 64'(expRd));
      end
      bus.rd_en = 1'b0;
      tick();
      modelActive = 1 - modelActive;
      checkOutput("deferred_swap_ack_fire", 64'(bus.swap_ack), 64'd1);
      checkOutput("deferred_active_bank_new", 64'(bus.active_bank), 64'(modelActive));
      bus.swap_req = 1'b0;
      readSweep("rd_pattern_a");

      $display("[TB] restart partway through a load");
      doneCount = 0;
      applyStimulus(20, 1'b0, 1'b0, 1'b1);
      applyStimulus(DEPTH, 1'b1, 1'b0, 1'b1);
      tick();
      checkOutput("restart_shadow_full", 64'(bus.shadow_full), 64'd1);
      checkOutput("restart_done_count", 64'(doneCount), 64'd1);
      doSwap();
      readSweep("rd_pattern_c");

      $display("[TB] reset during a load");
      applyStimulus(10, 1'b0, 1'b0, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      modelActive = 0;
      expBank     = modelActive;
      checkOutput("midload_shadow_full", 64'(bus.shadow_full), 64'd0);
      checkOutput("midload_active_bank", 64'(bus.active_bank), 64'(expBank));
      checkOutput("midload_load_ready", 64'(bus.load_ready), 64'd0);
      bus.swap_req = 1'b1;
      tick();
      checkOutput("post_reset_swap_ack", 64'(bus.swap_ack), 64'd0);
      bus.swap_req = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/kernel_weight_store.md
# kernel_weight_store

Double-buffered kernel weight memory for the convolution engine. It holds one active bank read by the conv module and one shadow bank filled by a streaming loader. Each word is one kernel position holding OUT_CHANNELS weights. A swap handshake makes a freshly loaded weight set active without stalling on a partially written bank. It replaces the single-port kernel BRAM, generalising it with a load handshake, an automatic address counter and ping-pong banking.

## Interface
- KERNEL_WEIGHT_BITS, 6, bits per weight
- KERNEL_SIZE, 3, kernel side length
- IN_CHANNELS, 6, input channels
- OUT_CHANNELS, 6, output channels packed per word
- DATA_WIDTH, KERNEL_WEIGHT_BITS*OUT_CHANNELS, word width; out-channel c occupies bits [c*KERNEL_WEIGHT_BITS +: KERNEL_WEIGHT_BITS]
- DEPTH, IN_CHANNELS*KERNEL_SIZE*KERNEL_SIZE, words per bank
- ADDR_WIDTH, $clog2(DEPTH), address width
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- load_start  in  1  begin (or restart) filling the shadow bank at address 0
- load_valid  in  1  load_data is valid
- load_data  in  DATA_WIDTH  weight word for the next shadow address
- load_ready  out  1  store accepts a word this cycle
- load_done  out  1  one-cycle pulse: shadow bank completely written
- shadow_full  out  1  shadow bank holds a complete set, awaiting swap
- swap_req  in  1  level request to make the shadow bank active; hold until swap_ack
- swap_ack  out  1  one-cycle pulse: banks swapped this edge
- active_bank  out  1  index of the bank currently read
- rd_en  in  1  read request from the conv module
- rd_addr  in  ADDR_WIDTH  read address into the active bank
- rd_data  out  DATA_WIDTH  read word
- rd_valid  out  1  rd_data valid (rd_en delayed one cycle)

## Operation
- Two banks of DEPTH x DATA_WIDTH. The shadow bank is always bank !active_bank. Reads touch only the active bank, writes only the shadow bank, so a read and a write in the same cycle never conflict.
- Load FSM has three states: IDLE, LOADING, FULL.
- IDLE:
  - load_ready=0, shadow_full=0.
  - load_start: write pointer wr_ptr←0, go to LOADING.
- LOADING:
  - load_ready=1.
  - On load_valid: write shadow[wr_ptr], wr_ptr++.
  - A write at wr_ptr==DEPTH-1 goes to FULL and pulses load_done on the next cycle.
  - load_start restarts: wr_ptr←0. A word presented in the same cycle is written at address 0 and wr_ptr←1.
- FULL:
  - shadow_full=1, load_ready=0.
  - swap_req && !rd_en: toggle active_bank, pulse swap_ack, go to IDLE.
  - swap_req && rd_en: swap is deferred while swap_req is held.
  - load_start: discard the full set, go to LOADING with wr_ptr←0. load_start wins over a swap in the same cycle.
- swap_req outside FULL is ignored: no ack and no state change.
- Read path:
  - rd_data is registered from the active bank.
  - rd_addr ≥ DEPTH returns all-zero rd_data, with rd_valid still asserted.
  - Without rd_en, rd_data holds its last value.
- Bank contents are not cleared by reset. Reading a bank that has never been loaded returns undefined data, and the bench must not check it.

## Timing
- Reset values: load_ready=0, load_done=0, shadow_full=0, swap_ack=0, active_bank=0, rd_data=0, rd_valid=0, FSM=IDLE, wr_ptr=0.
- rst asserted mid-load or while FULL aborts the load. Shadow contents are retained but never marked full.
- Read latency is 1: rd_en/rd_addr at edge N gives rd_data/rd_valid after edge N+1. rd_valid is asserted only for that single cycle.
- Load throughput is one word per cycle. Minimum time from load_start to load_done pulse is DEPTH+1 cycles.
- load_done and shadow_full rise in the same cycle.
- Swap is single-cycle. At the edge where swap_ack is registered, active_bank toggles.
- A read issued in the cycle swap_ack is high uses the new bank. A read issued the cycle before uses the old bank.
- Once a load is complete, the first swap opportunity is the cycle after shadow_full rises.

## Test plan
- Reset, load_start, then 54 words (defaults) with value = address and load_valid held: load_ready high for 54 cycles, load_done pulses once, shadow_full=1. Reads of bank 0 are not checked.
- From FULL, assert swap_req with rd_en=0: swap_ack pulses next edge, active_bank=1. Then rd_addr=17 gives rd_data=17 with rd_valid exactly one cycle later.
- Hold swap_req while rd_en stays high for 5 cycles: no swap_ack during those cycles. swap_ack comes in the first cycle rd_en=0.
- Load bank 0 with pattern A while continuously reading bank 1 (pattern B): every rd_data matches B throughout. After the swap, reads return A.
- Restart partway through: load_start after 20 words, then 54 words of pattern C. Final contents are all C, and load_done pulses exactly once.
- Edge cases:
  - rd_addr=54 gives rd_data=0 with rd_valid=1.
  - swap_req in IDLE gives no ack.
  - rst asserted mid-load gives shadow_full=0 and active_bank=0.
